// File: rtl/commit_trace_sink_if.sv
// Drain side of the commit trace sink: head record plus valid/ready handshake.
// The sink drives through the master modport, the consumer uses the slave modport.
interface commit_trace_sink_if #(
  parameter int XLEN     = 16,
  parameter int REG_BITS = 3,
  parameter int SEQ_W    = 16
);
  logic                trace_valid;
  logic                trace_ready;
  logic [SEQ_W-1:0]    trace_seq;
  logic [XLEN-1:0]     trace_pc;
  logic [XLEN-1:0]     trace_insn;
  logic                trace_rd_we;
  logic [REG_BITS-1:0] trace_rd;
  logic [XLEN-1:0]     trace_rd_data;

  modport master (
    output trace_valid, trace_seq, trace_pc, trace_insn,
           trace_rd_we, trace_rd, trace_rd_data,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_seq, trace_pc, trace_insn,
           trace_rd_we, trace_rd, trace_rd_data,
    output trace_ready
  );
endinterface

// File: rtl/commit_trace_sink.sv
// Captures the core's commit stream into a sequence-stamped FWFT FIFO with drop accounting.
// The connected interface must be built with the same XLEN/REG_BITS/SEQ_W as this module.
module commit_trace_sink #(
  parameter int XLEN     = 16,
  parameter int REG_BITS = 3,
  parameter int DEPTH    = 16,
  parameter int SEQ_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      clear,
  input  logic                      commit_valid,
  input  logic [XLEN-1:0]           commit_pc,
  input  logic [XLEN-1:0]           commit_insn,
  input  logic                      commit_rd_we,
  input  logic [REG_BITS-1:0]       commit_rd,
  input  logic [XLEN-1:0]           commit_rd_data,
  commit_trace_sink_if.master       trace,
  output logic [$clog2(DEPTH):0]    level,
  output logic [15:0]               drop_cnt,
  output logic                      overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [SEQ_W-1:0]    mem_seq  [DEPTH];
  logic [XLEN-1:0]     mem_pc   [DEPTH];
  logic [XLEN-1:0]     mem_insn [DEPTH];
  logic                mem_we   [DEPTH];
  logic [REG_BITS-1:0] mem_rd   [DEPTH];
  logic [XLEN-1:0]     mem_data [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [SEQ_W-1:0] seq_cnt;

  logic flush;
  logic capture;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // A pop frees the slot the push lands in, so a full FIFO still accepts when draining.
  always_comb begin
    flush   = rst || clear;
    capture = commit_valid && enable;
    empty   = (level == '0);
    full    = (level == FULL_LVL);
    pop     = !empty && trace.trace_ready;
    push    = capture && (!full || pop);
    drop    = capture && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  // Dropped records still burn a sequence number so the consumer sees the gap.
  always_ff @(posedge clk) begin
    if (flush) begin
      seq_cnt  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) begin
        seq_cnt <= seq_cnt + SEQ_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_seq[wr_ptr]  <= seq_cnt;
      mem_pc[wr_ptr]   <= commit_pc;
      mem_insn[wr_ptr] <= commit_insn;
      mem_we[wr_ptr]   <= commit_rd_we;
      mem_rd[wr_ptr]   <= commit_rd;
      mem_data[wr_ptr] <= commit_rd_data;
    end
  end

  // Head is read straight from storage; fields are forced to zero while empty.
  always_comb begin
    trace.trace_valid   = !empty;
    trace.trace_seq     = '0;
    trace.trace_pc      = '0;
    trace.trace_insn    = '0;
    trace.trace_rd_we   = 1'b0;
    trace.trace_rd      = '0;
    trace.trace_rd_data = '0;
    if (!empty) begin
      trace.trace_seq     = mem_seq[rd_ptr];
      trace.trace_pc      = mem_pc[rd_ptr];
      trace.trace_insn    = mem_insn[rd_ptr];
      trace.trace_rd_we   = mem_we[rd_ptr];
      trace.trace_rd      = mem_rd[rd_ptr];
      trace.trace_rd_data = mem_data[rd_ptr];
    end
  end

endmodule

// File: doc/commit_trace_sink.md
Name: commit_trace_sink

Overview:
- Receives the per-instruction commit record stream the CPU core drives, one record per cycle, with no backpressure to the core.
- Stamps each record with a sequence number and buffers it in a first-word-fall-through FIFO.
- Presents records on a valid/ready drain port for the testbench scoreboard or host debug logic.
- Counts and flags records dropped on overflow, so trace gaps are detectable.

Parameters:
- XLEN, 16, data/PC/instruction width in bits
- REG_BITS, 3, architectural register index width
- DEPTH, 16, FIFO entries; power of two, minimum 2
- SEQ_W, 16, sequence-number width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  capture enable; when 0, commits are ignored (not counted, not sequenced)
- clear  in  1  synchronous flush of FIFO, sequence counter, drop counter and overflow flag
- commit_valid  in  1  core retired an instruction this cycle
- commit_pc  in  XLEN  PC of retired instruction
- commit_insn  in  XLEN  instruction word
- commit_rd_we  in  1  instruction wrote a register
- commit_rd  in  REG_BITS  destination register index
- commit_rd_data  in  XLEN  value written
- trace_valid  out  1  head entry available
- trace_ready  in  1  consumer accepts head
- trace_seq  out  SEQ_W  sequence number of head
- trace_pc, trace_insn, trace_rd_data  out  XLEN  head fields
- trace_rd_we  out  1  head field
- trace_rd  out  REG_BITS  head field
- level  out  $clog2(DEPTH)+1  current occupancy
- drop_cnt  out  16  saturating count of dropped records
- overflow  out  1  sticky; set on first drop

Behaviour:
- Reset (rst=1): FIFO empty, trace_valid=0, level=0, sequence counter=0, drop_cnt=0, overflow=0. All trace_* data outputs=0 while empty.
- clear behaves identically to rst. rst has priority over everything; clear has priority over push/pop in the same cycle.
- Capture event: commit_valid && enable.
  - Every capture event consumes one sequence number: the record gets the current counter value, then the counter increments.
  - Dropped records also consume a number, so the consumer sees gaps.
  - The counter wraps modulo 2^SEQ_W.
- pop = trace_valid && trace_ready.
- push = capture && (level<DEPTH || pop).
  - Full FIFO with simultaneous pop: the push is accepted and level stays DEPTH.
- Drop = capture && level==DEPTH && !pop.
  - drop_cnt increments, saturating at 16'hFFFF.
  - overflow is set and stays set until rst/clear.
- Latency: a record captured in cycle N appears on trace_* in cycle N+1 if the FIFO was empty.
  - No combinational path from commit_* to trace_*.
- Push and pop in the same cycle on an empty FIFO: impossible, since trace_valid=0 then; the push lands and is visible next cycle.
- Simultaneous push and pop with 0<level<DEPTH: level unchanged, order preserved.
- FWFT: trace_* holds the head stable while trace_valid=1 && trace_ready=0.
- Pointers are $clog2(DEPTH)-bit and wrap naturally. Full/empty are derived from level.
- level updates by +1 on push only, −1 on pop only, 0 on both or neither.
- enable deassert mid-stream: buffered entries still drain; subsequent commits are not sequenced.
- Reset or clear mid-drain discards all entries; trace_valid falls in the next cycle.

Test Plan:
- Reset, then 3 commits (pc 0x0000/0x0002/0x0004) with trace_ready=1 -> trace_valid from the cycle after the first commit, seq 0,1,2 in order, fields match, level returns to 0.
- DEPTH=16, trace_ready=0, 20 back-to-back commits -> level=16, drop_cnt=4, overflow=1. Draining yields seq 0..15; the next commit gets seq 20.
- Full FIFO, commit_valid=1 and trace_ready=1 for 5 cycles -> no drops, level stays 16, drain order contiguous.
- Hold trace_ready=0 for 3 cycles with entry seq 7 at head -> trace_* stable at seq 7; trace_ready=1 advances to seq 8.
- enable=0 during 4 commits, then enable=1 and 1 commit -> only that record appears, with seq continuing from the last enabled value.
- Assert clear with level=9, drop_cnt=2 -> next cycle level=0, trace_valid=0, drop_cnt=0, overflow=0; the next commit gets seq 0.
